// File: rtl/ysyx_23060061_ifu.sv
// ysyx_23060061_ifu: instruction fetch unit with in-order imem request/response
// handling, a QDEPTH-entry instruction queue, and redirect with flush.
//
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   imem_req_valid/ready/addr word fetch request channel
//   imem_rsp_valid/data       in-order fetch responses (always accepted)
//   redirect_valid/pc         flush the queue and restart fetch at a new PC
//   halt                      level; stops issuing new requests
//   inst_valid/ready/data/pc  {pc, inst} handoff to decode
//   busy                      requests in flight, pending drops or queue non-empty
//
// Build option: define IFU_BYPASS_EN to let a response reach decode in the same
// cycle when the queue is empty; without it every response goes through the queue.
module ysyx_23060061_ifu #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h80000000,
  parameter int QDEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            busy
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int SW = AW + 3;
  logic [XLEN-1:0] fetch_pc, rsp_pc, redir_al;
  logic [CW-1:0]   outstanding, drop_cnt, count;
  logic [AW-1:0]   head, tail;
  logic [31:0]     q_data [QDEPTH];
  logic [XLEN-1:0] q_pc [QDEPTH];
  logic [SW-1:0]   credit;
  logic            req_fire, rsp_take, rsp_drop, push, pop, byp;
  assign redir_al = redirect_pc & ~XLEN'(3);
  // Every request, queued entry and pending drop holds a slot, so the queue
  // can never overflow and responses never need backpressure.
  assign credit = SW'(outstanding) + SW'(count) + SW'(drop_cnt);
  assign imem_req_valid = rst && !halt && !redirect_valid && credit < SW'(QDEPTH);
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && drop_cnt == '0;
  assign rsp_drop = imem_rsp_valid && drop_cnt != '0;
`ifdef IFU_BYPASS_EN
  assign byp = rst && rsp_take && count == '0;
`else
  assign byp = 1'b0;
`endif
  assign inst_valid = rst && !redirect_valid && (count != '0 || byp);
  assign inst_data = count != '0 ? q_data[head] : byp ? imem_rsp_data : '0;
  assign inst_pc = count != '0 ? q_pc[head] : byp ? rsp_pc : RESET_PC;
  assign pop = inst_valid && inst_ready && count != '0;
  assign push = rsp_take && !(byp && inst_ready);
  assign busy = outstanding != '0 || drop_cnt != '0 || count != '0;
  // rsp_pc is the PC of the next response that will be kept; responses are
  // in order, so it advances only on kept responses and restarts on redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redir_al;
      rsp_pc <= redir_al;
      // a response arriving now is discarded too, using up one slot either way
      drop_cnt <= drop_cnt + outstanding - CW'(imem_rsp_valid);
      outstanding <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (rsp_take) rsp_pc <= rsp_pc + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      drop_cnt <= drop_cnt - CW'(rsp_drop);
      count <= count + CW'(push) - CW'(pop);
      if (push) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      q_data[tail] <= imem_rsp_data;
      q_pc[tail] <= rsp_pc;
    end
  end
endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// tb_ysyx_23060061_ifu: scoreboard bench with a variable-latency imem model.
module tb_ysyx_23060061_ifu;
  localparam logic [31:0] RPC = 32'h80000000;
`ifdef IFU_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif
  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  logic clk = 0, rst = 0;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, halt;
  logic inst_valid, inst_ready, busy;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, inst_data, inst_pc;
  pend_t pend[$];
  exp_t exp_q[$];
  logic [31:0] req_log[$], pop_log[$];
  int checks = 0, errors = 0, cyc = 0, lat = 1, nreq = 0, pops = 0;
  int first_req = -1, first_val = -1;

  ysyx_23060061_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(logic [31:0] a);
    return {a[7:0], a[15:8], a[23:16], a[31:24]} ^ 32'h13579BDF;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // imem model: in-order responses, each no earlier than lat cycles after its request
  initial begin
    imem_rsp_valid = 0;
    imem_rsp_data = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        pend.delete();
        imem_rsp_valid = 0;
      end else begin
        if (imem_rsp_valid) pend.delete(0);
        if (pend.size() != 0 && pend[0].due <= cyc) begin
          imem_rsp_valid = 1;
          imem_rsp_data = mem_f(pend[0].addr);
        end else imem_rsp_valid = 0;
      end
    end
  end

  // monitor and scoreboard, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (!rst) exp_q.delete();
    else begin
      if (inst_valid && first_val < 0) first_val = cyc;
      if (inst_valid && inst_ready) begin
        exp_t e;
        pops++;
        pop_log.push_back(inst_pc);
        if (exp_q.size() == 0) chk("spurious_pop", inst_pc, 32'hxxxxxxxx);
        else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_data", inst_data, e.data);
        end
      end
      if (redirect_valid) exp_q.delete();
      if (imem_req_valid && imem_req_ready) begin
        if (first_req < 0) first_req = cyc;
        nreq++;
        req_log.push_back(imem_req_addr);
        pend.push_back('{addr: imem_req_addr, due: cyc + lat});
        exp_q.push_back('{pc: imem_req_addr, data: mem_f(imem_req_addr)});
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 60) begin
      tick();
      i++;
    end
    chk("idle", busy, 0);
  endtask

  task automatic wait_req(int n);
    int i = 0;
    while (nreq < n && i < 40) begin
      tick();
      i++;
    end
    chk("req_wait", 32'(nreq >= n), 1);
  endtask

  task automatic redirect(logic [31:0] pc);
    redirect_valid = 1;
    redirect_pc = pc;
    #1;
    chk("redir_req_valid", imem_req_valid, 0);
    chk("redir_inst_valid", inst_valid, 0);
    tick();
    redirect_valid = 0;
  endtask

  initial begin
    int p0;
    imem_req_ready = 1;
    redirect_valid = 0;
    redirect_pc = 0;
    halt = 0;
    inst_ready = 1;
    tick(2);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, RPC);
    chk("rst_busy", busy, 0);
    // streaming fetch
    first_req = -1;
    first_val = -1;
    rst = 1;
    tick(14);
    chk("req0", req_log[0], RPC);
    chk("req1", req_log[1], RPC + 4);
    chk("req2", req_log[2], RPC + 8);
    chk("first_lat", 32'(first_val - first_req), 32'(FIRST_LAT));
    chk("stream_pop1", pop_log[1], RPC + 4);
    chk("stream_rate", 32'(pops >= 10), 1);
    // fill queue with decode stalled
    halt = 1;
    wait_idle();
    inst_ready = 0;
    nreq = 0;
    halt = 0;
    tick(12);
    chk("fill_nreq", nreq, 4);
    chk("fill_req_valid", imem_req_valid, 0);
    chk("fill_inst_valid", inst_valid, 1);
    p0 = pops;
    halt = 1;
    inst_ready = 1;
    tick(8);
    chk("drain_pops", 32'(pops - p0), 4);
    chk("drain_busy", busy, 0);
    // redirect with three requests outstanding on a 3-cycle imem
    lat = 3;
    nreq = 0;
    halt = 0;
    wait_req(3);
    req_log.delete();
    pop_log.delete();
    redirect(32'h80000102);
    tick(12);
    chk("redir_addr", req_log[0], 32'h80000100);
    chk("redir_pc0", pop_log[0], 32'h80000100);
    chk("redir_pc1", pop_log[1], 32'h80000104);
    // redirect colliding with a response and a pop
    lat = 1;
    tick(6);
    chk("steady_valid", inst_valid, 1);
    pop_log.delete();
    redirect(32'h80000400);
    tick(8);
    chk("flush_pc0", pop_log[0], 32'h80000400);
    chk("flush_pc1", pop_log[1], 32'h80000404);
    // halt with two in flight
    halt = 1;
    wait_idle();
    redirect(32'h80000800);
    lat = 3;
    nreq = 0;
    req_log.delete();
    pop_log.delete();
    halt = 0;
    wait_req(2);
    halt = 1;
    wait_idle();
    chk("halt_nreq", nreq, 2);
    chk("halt_npops", pop_log.size(), 2);
    chk("halt_pop0", pop_log[0], 32'h80000800);
    chk("halt_pop1", pop_log[1], 32'h80000804);
    req_log.delete();
    halt = 0;
    wait_req(3);
    chk("resume_addr", req_log[0], 32'h80000808);
    // PC wrap
    lat = 1;
    halt = 1;
    wait_idle();
    req_log.delete();
    pop_log.delete();
    redirect(32'hFFFFFFFC);
    halt = 0;
    tick(5);
    chk("wrap0", req_log[0], 32'hFFFFFFFC);
    chk("wrap1", req_log[1], 32'h00000000);
    chk("wrap_pop1", pop_log[1], 32'h00000000);
    chk("pre_rst_busy", busy, 1);
    // asynchronous reset mid-burst
    #1;
    rst = 0;
    #1;
    chk("arst_req_valid", imem_req_valid, 0);
    chk("arst_req_addr", imem_req_addr, RPC);
    chk("arst_inst_valid", inst_valid, 0);
    chk("arst_inst_data", inst_data, 0);
    chk("arst_inst_pc", inst_pc, RPC);
    chk("arst_busy", busy, 0);
    tick(2);
    req_log.delete();
    pop_log.delete();
    rst = 1;
    tick(6);
    chk("post_rst_addr", req_log[0], RPC);
    chk("post_rst_pop0", pop_log[0], RPC);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
